// File: rtl/mac_array_gen.sv
// N_CH-channel dot-product engine: K_LEN-term MACs per group, N_GRP groups per job,
// coefficients streamed from a packed ROM, wrap or saturating accumulation.

module mac_array_lane #(
   parameter int X_W   = 9,
   parameter int C_W   = 7,
   parameter int ACC_W = 18
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_beat,
   input  logic             i_first,
   input  logic             i_last,
   input  logic             i_sat,
   input  logic [X_W-1:0]   i_x,
   input  logic [C_W-1:0]   i_coef,
   output logic [ACC_W-1:0] o_acc,
   output logic             o_ovf
);
   localparam int P_W = X_W + C_W;

   logic [ACC_W-1:0] r_acc;
   logic             r_sticky;
   logic [P_W-1:0]   w_prod;
   logic [ACC_W:0]   w_base;
   logic [ACC_W:0]   w_sum;
   logic             w_ovf;
   logic [ACC_W-1:0] w_next;

   assign w_prod = P_W'(i_x) * P_W'(i_coef);
   assign w_base = i_first ? '0 : {1'b0, r_acc};
   assign w_sum  = w_base + (ACC_W+1)'(w_prod);
   // The sticky flag belongs to the previous group when this is term 0.
   assign w_ovf  = w_sum[ACC_W] | (~i_first & r_sticky);
   assign w_next = (i_sat && w_ovf) ? '1 : w_sum[ACC_W-1:0];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_acc    <= '0;
         r_sticky <= 1'b0;
         o_acc    <= '0;
         o_ovf    <= 1'b0;
      end else if (i_beat) begin
         r_acc    <= w_next;
         r_sticky <= w_ovf;
         if (i_last) begin
            o_acc <= w_next;
            o_ovf <= w_ovf;
         end
      end
   end
endmodule

module mac_array_gen #(
   parameter int N_CH          = 4,
   parameter int X_W           = 9,
   parameter int C_W           = 7,
   parameter int ACC_W         = 18,
   parameter int K_LEN         = 8,
   parameter int COEF_PER_WORD = 2,
   parameter int N_GRP         = 4,
   parameter int ADDR_W        = 4,
   localparam int G_W = (N_GRP > 1) ? $clog2(N_GRP) : 1
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       start,
   input  logic                       sat_en,
   input  logic [N_CH*X_W-1:0]        x_data,
   input  logic                       x_valid,
   output logic                       x_ready,
   input  logic [COEF_PER_WORD*C_W-1:0] coef_word,
   output logic [ADDR_W-1:0]          rom_addr,
   output logic [N_CH*ACC_W-1:0]      acc_out,
   output logic [N_CH-1:0]            ovf,
   output logic                       out_valid,
   output logic [G_W-1:0]             grp_idx,
   output logic                       busy,
   output logic                       done
);
   localparam int K_W = (K_LEN > 1) ? $clog2(K_LEN) : 1;
   localparam int S_W = (COEF_PER_WORD > 1) ? $clog2(COEF_PER_WORD) : 1;

   localparam logic [0:0] S_IDLE = 1'b0;
   localparam logic [0:0] S_RUN  = 1'b1;

   logic [0:0]        r_state;
   logic [K_W-1:0]    r_k;
   logic [G_W-1:0]    r_g;
   logic [S_W-1:0]    r_slot;
   logic [ADDR_W-1:0] r_addr;
   logic              r_sat;
   logic              r_out_valid;
   logic              r_done;
   logic [G_W-1:0]    r_grp;

   logic                               w_beat;
   logic                               w_first;
   logic                               w_last_k;
   logic                               w_last_g;
   logic                               w_word_end;
   logic [COEF_PER_WORD-1:0][C_W-1:0]  w_slots;
   logic [C_W-1:0]                     w_coef;
   logic [N_CH-1:0][X_W-1:0]           w_x;
   logic [N_CH-1:0][ACC_W-1:0]         w_acc;

   assign w_beat     = x_valid && (r_state == S_RUN);
   assign w_first    = (r_k == '0);
   assign w_last_k   = (r_k == K_W'(K_LEN-1));
   assign w_last_g   = (r_g == G_W'(N_GRP-1));
   assign w_word_end = (r_slot == S_W'(COEF_PER_WORD-1));

   // Slot 0 sits in the most significant slice of the ROM word.
   assign w_slots = coef_word;
   assign w_coef  = w_slots[S_W'(COEF_PER_WORD-1) - r_slot];
   assign w_x     = x_data;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= S_IDLE;
         r_k         <= '0;
         r_g         <= '0;
         r_slot      <= '0;
         r_addr      <= '0;
         r_sat       <= 1'b0;
         r_out_valid <= 1'b0;
         r_done      <= 1'b0;
         r_grp       <= '0;
      end else begin
         r_out_valid <= 1'b0;
         r_done      <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_state <= S_RUN;
                  r_k     <= '0;
                  r_g     <= '0;
                  r_slot  <= '0;
                  r_addr  <= '0;
                  r_sat   <= sat_en;
               end
            end
            S_RUN: begin
               if (w_beat) begin
                  r_slot <= w_word_end ? '0 : r_slot + S_W'(1);
                  if (w_word_end) r_addr <= r_addr + ADDR_W'(1);
                  if (w_last_k) begin
                     r_k         <= '0;
                     r_g         <= r_g + G_W'(1);
                     r_out_valid <= 1'b1;
                     r_grp       <= r_g;
                     if (w_last_g) begin
                        r_done  <= 1'b1;
                        r_state <= S_IDLE;
                     end
                  end else begin
                     r_k <= r_k + K_W'(1);
                  end
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   for (genvar c = 0; c < N_CH; c++) begin : g_lane
      mac_array_lane #(
         .X_W   (X_W),
         .C_W   (C_W),
         .ACC_W (ACC_W)
      ) u_lane (
         .clk     (clk),
         .rst     (rst),
         .i_beat  (w_beat),
         .i_first (w_first),
         .i_last  (w_last_k),
         .i_sat   (r_sat),
         .i_x     (w_x[c]),
         .i_coef  (w_coef),
         .o_acc   (w_acc[c]),
         .o_ovf   (ovf[c])
      );
   end

   assign acc_out   = w_acc;
   assign x_ready   = (r_state == S_RUN);
   assign busy      = (r_state == S_RUN);
   assign rom_addr  = r_addr;
   assign out_valid = r_out_valid;
   assign done      = r_done;
   assign grp_idx   = r_grp;
endmodule

// File: tb/tb_mac_array_gen.sv
// Directed bench for mac_array_gen: ROM model, out_valid monitor, hand-computed results.

module tb_mac_array_gen;
   localparam int N_CH = 4, X_W = 9, C_W = 7, ACC_W = 18;
   localparam int K_LEN = 8, CPW = 2, N_GRP = 4, ADDR_W = 4;

   logic                    clk = 1'b0;
   logic                    rst;
   logic                    start;
   logic                    sat_en;
   logic [N_CH*X_W-1:0]     x_data;
   logic                    x_valid;
   logic                    x_ready;
   logic [CPW*C_W-1:0]      coef_word;
   logic [ADDR_W-1:0]       rom_addr;
   logic [N_CH*ACC_W-1:0]   acc_out;
   logic [N_CH-1:0]         ovf;
   logic                    out_valid;
   logic [1:0]              grp_idx;
   logic                    busy;
   logic                    done;

   logic [CPW*C_W-1:0] rom [16];
   assign coef_word = rom[rom_addr];

   mac_array_gen #(
      .N_CH(N_CH), .X_W(X_W), .C_W(C_W), .ACC_W(ACC_W), .K_LEN(K_LEN),
      .COEF_PER_WORD(CPW), .N_GRP(N_GRP), .ADDR_W(ADDR_W)
   ) dut (
      .clk(clk), .rst(rst), .start(start), .sat_en(sat_en),
      .x_data(x_data), .x_valid(x_valid), .x_ready(x_ready),
      .coef_word(coef_word), .rom_addr(rom_addr),
      .acc_out(acc_out), .ovf(ovf), .out_valid(out_valid),
      .grp_idx(grp_idx), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [N_CH*ACC_W-1:0] acc;
      logic [N_CH-1:0]       ovf;
      logic [1:0]            grp;
      logic                  done;
      logic                  busy;
      int                    cyc;
   } ev_t;

   ev_t ev_q[$];
   ev_t mon_e;
   always @(negedge clk) begin
      if (out_valid) begin
         mon_e.acc  = acc_out;
         mon_e.ovf  = ovf;
         mon_e.grp  = grp_idx;
         mon_e.done = done;
         mon_e.busy = busy;
         mon_e.cyc  = cyc;
         ev_q.push_back(mon_e);
      end
   end

   int n_chk = 0;
   int n_err = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s obs=%0d exp=%0d", tag, obs, exp);
      end
   endtask

   int              exp_acc [N_CH];
   logic [N_CH-1:0] exp_ovf;

   // xv < 0 selects per-channel x = c+1
   task automatic set_data(input int xv, input logic [C_W-1:0] c0, input logic [C_W-1:0] c1);
      for (int c = 0; c < N_CH; c++)
         x_data[c*X_W +: X_W] = (xv < 0) ? X_W'(c + 1) : X_W'(xv);
      for (int i = 0; i < 16; i++) rom[i] = {c0, c1};
   endtask

   task automatic run_job(input bit sat, input bit skip_start, input int stall_beat,
                          input int start_beat, input bit chain);
      int t0;
      int hold;
      int exp_cyc;
      ev_t e;
      if (!skip_start) begin
         @(negedge clk);
         start = 1'b1; sat_en = sat;
         @(negedge clk);
         start = 1'b0;
         chk("busy_rise", busy, 1);
      end
      ev_q.delete();
      t0 = cyc;
      for (int b = 0; b < K_LEN*N_GRP; b++) begin
         if (b == stall_beat) begin
            x_valid = 1'b0;
            hold = rom_addr;
            repeat (3) @(negedge clk);
            chk("stall_addr_hold", rom_addr, hold);
         end
         x_valid = 1'b1;
         start   = (b == start_beat);
         chk("rom_addr", rom_addr, b / CPW);
         @(negedge clk);
      end
      x_valid = 1'b0;
      start   = chain;
      #1;
      chk("n_pulses", ev_q.size(), N_GRP);
      for (int g = 0; g < N_GRP; g++) begin
         if (g < ev_q.size()) begin
            e = ev_q[g];
            exp_cyc = t0 + K_LEN*(g+1) + ((stall_beat >= 0 && stall_beat < K_LEN*(g+1)) ? 3 : 0);
            for (int c = 0; c < N_CH; c++)
               chk("acc_out", e.acc[c*ACC_W +: ACC_W], exp_acc[c]);
            chk("ovf", e.ovf, exp_ovf);
            chk("grp_idx", e.grp, g);
            chk("done", e.done, g == N_GRP-1);
            chk("busy_at_pulse", e.busy, g != N_GRP-1);
            chk("pulse_cycle", e.cyc, exp_cyc);
         end
      end
      @(negedge clk);
      start = 1'b0;
      chk("out_valid_drop", out_valid, 0);
      chk("done_drop", done, 0);
      chk("busy_after", busy, chain);
      chk("x_ready_after", x_ready, chain);
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; sat_en = 1'b0; x_valid = 1'b0; x_data = '0;
      for (int i = 0; i < 16; i++) rom[i] = '0;
      repeat (3) @(negedge clk);
      chk("rst_acc", acc_out, 0);
      chk("rst_ovf", ovf, 0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_x_ready", x_ready, 0);
      chk("rst_rom_addr", rom_addr, 0);
      rst = 1'b0;

      // basic: all ones
      set_data(1, 7'd1, 7'd1);
      for (int c = 0; c < N_CH; c++) exp_acc[c] = 8;
      exp_ovf = '0;
      run_job(1'b0, 1'b0, -1, -1, 1'b0);

      // distinct data, stray start at beat 5, then a back-to-back job
      set_data(-1, 7'd2, 7'd3);
      for (int c = 0; c < N_CH; c++) exp_acc[c] = 20 * (c + 1);
      run_job(1'b0, 1'b0, -1, 5, 1'b1);
      run_job(1'b0, 1'b1, -1, -1, 1'b0);

      // saturate then wrap at full-scale inputs
      set_data(511, 7'd127, 7'd127);
      for (int c = 0; c < N_CH; c++) exp_acc[c] = 262143;
      exp_ovf = '1;
      run_job(1'b1, 1'b0, -1, -1, 1'b0);
      for (int c = 0; c < N_CH; c++) exp_acc[c] = 257032;
      run_job(1'b0, 1'b0, -1, -1, 1'b0);

      // 3-cycle stall in the middle of group 1
      set_data(1, 7'd1, 7'd1);
      for (int c = 0; c < N_CH; c++) exp_acc[c] = 8;
      exp_ovf = '0;
      run_job(1'b0, 1'b0, 12, -1, 1'b0);

      // reset after 13 beats
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      x_valid = 1'b1;
      repeat (13) @(negedge clk);
      rst = 1'b1;
      #1;
      chk("midrst_acc", acc_out, 0);
      chk("midrst_ovf", ovf, 0);
      chk("midrst_busy", busy, 0);
      chk("midrst_rom_addr", rom_addr, 0);
      chk("midrst_grp", grp_idx, 0);
      ev_q.delete();
      x_valid = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      x_valid = 1'b1;
      repeat (10) @(negedge clk);
      chk("idle_x_ready", x_ready, 0);
      chk("idle_no_pulse", ev_q.size(), 0);
      chk("idle_rom_addr", rom_addr, 0);
      x_valid = 1'b0;
      run_job(1'b0, 1'b0, -1, -1, 1'b0);

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end
endmodule
